// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants and types for the push-button BCD counters.
// Holds the BCD digit type, its largest legal value and the default debounce time.
package kbd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'h9;

    // 20 ms of stable key level at a 50 MHz clock.
    localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 1_000_000;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser, optional stable-level debouncer and rising-edge step pulse.
// Define BCD_KEY_COUNTER_DEBOUNCE_EN to insert the debouncer; otherwise the synchronised key is edge-detected directly.
module key_debounce
    import kbd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic step_p
);

    logic [1:0] sync_q, sync_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;
    logic       key_s;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    assign key_s = sync_q[1];

    // A key still held when reset releases must be seen low once before it can step.
    always_comb begin
        sync_d  = {sync_q[0], key_raw};
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~key_s);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
        end
    end

`ifdef BCD_KEY_COUNTER_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip;

    // The pulse fires in the cycle the stable level rises, so the count moves on the flip edge.
    always_comb begin
        flip     = (key_s != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
        stable_d = flip ? key_s : stable_q;
        cnt_d    = ((key_s == stable_q) || flip) ? '0 : cnt_q + 1'b1;
        step_p   = flip & key_s & armed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    logic prev_q, prev_d;

    always_comb begin
        prev_d = key_s;
        step_p = key_s & ~prev_q & armed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end
`endif

endmodule

// File: rtl/bcd_key_counter.sv
// bcd_key_counter: DIGITS-wide BCD up/down counter stepped by two push-buttons, wrap or saturate at the limits.
// BCD_KEY_COUNTER_DEBOUNCE_EN enables per-key debouncing of DEBOUNCE_CYCLES cycles.
module bcd_key_counter
    import kbd_pkg::*;
#(
    parameter int unsigned DIGITS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter bit          SATURATE        = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_up,
    input  logic                  key_down,
    input  logic                  clr,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   cnt_out,
    output logic                  wrap_pulse,
    output logic                  at_max,
    output logic                  at_zero
);

    bcd_digit_t [DIGITS-1:0] cnt_q, cnt_d, inc_val, dec_val;
    logic       [DIGITS:0]   carry, borrow;
    logic                    wrap_q, wrap_d;
    logic                    up_p, down_p;
    logic                    step_up, step_dn;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_param
        $error("bcd_key_counter: DIGITS must be in 1..8");
    end

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_up),
        .step_p  (up_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_down),
        .step_p  (down_p)
    );

    // Ripple carry/borrow chains; their final stages double as the all-nines / all-zero decodes.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign inc_val[i]  = !carry[i]  ? cnt_q[i] :
                             (cnt_q[i] == BCD_MAX) ? bcd_digit_t'(0) : cnt_q[i] + 4'd1;
        assign dec_val[i]  = !borrow[i] ? cnt_q[i] :
                             (cnt_q[i] == 4'h0) ? BCD_MAX : cnt_q[i] - 4'd1;
        assign carry[i+1]  = carry[i]  & (cnt_q[i] == BCD_MAX);
        assign borrow[i+1] = borrow[i] & (cnt_q[i] == 4'h0);
    end

    assign at_max  = carry[DIGITS];
    assign at_zero = borrow[DIGITS];

    // NOTE: every variable gets a default before the priority chain so no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        step_up = en & up_p & ~down_p;
        step_dn = en & down_p & ~up_p;
        if (clr) begin
            cnt_d = '0;
        end else if (step_up) begin
            if (!(SATURATE && at_max)) begin
                cnt_d  = inc_val;
                wrap_d = at_max;
            end
        end else if (step_dn) begin
            if (!(SATURATE && at_zero)) begin
                cnt_d  = dec_val;
                wrap_d = at_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_out    = cnt_q;
    assign wrap_pulse = wrap_q;

endmodule
